// File: rtl/demux_ctrl_pkg.sv
// Shared types and constants for the packet demux router controller.
package demux_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

endpackage

// File: rtl/demux_out_reg.sv
// Single valid/ready register stage holding one beat (data plus last flag).
module demux_out_reg #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         take,
  output logic         full,
  output logic [W-1:0] q
);

  // A load wins over a take so a same-cycle handoff refills without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_router_ctrl.sv
// Header-routed packet demultiplexer: first beat selects the output, payload
// beats go through one register stage, packets to disabled outputs are dropped.
module demux_router_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NOUT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  input  logic            in_last,
  output logic            in_ready,
  input  logic [NOUT-1:0] en_mask,
  output logic [NOUT-1:0] out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  input  logic [NOUT-1:0] out_ready,
  output logic            busy,
  output logic [7:0]      drop_cnt
);

  localparam int DEST_W = $clog2(NOUT);

  state_t            state, state_nx;
  logic [DEST_W-1:0] dest, dest_q;
  logic              reg_full, take, accept, load, cnt_inc;
  logic [DW:0]       reg_q;

  assign dest   = in_data[DEST_W-1:0];
  assign take   = reg_full & out_ready[dest_q];
  assign accept = in_valid & in_ready;
  assign load   = accept & (state == FWD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !in_last) state_nx = en_mask[dest] ? FWD : DROP;
      FWD:     if (accept && in_last)  state_nx = IDLE;
      DROP:    if (accept && in_last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    cnt_inc  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    in_ready = ~reg_full;
        FWD:     in_ready = ~reg_full | out_ready[dest_q];
        DROP:    in_ready = 1'b1;
        default: in_ready = 1'b0;
      endcase
    end
    cnt_inc = accept & in_last & ((state == IDLE) | (state == DROP));
  end

  // dest_q only moves on a forwarded header, which needs an empty register,
  // so it stays valid until the previous packet's last beat has drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_q <= '0;
    end else if ((state == IDLE) && accept && !in_last && en_mask[dest]) begin
      dest_q <= dest;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (cnt_inc && (drop_cnt != DROP_CNT_MAX)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  demux_out_reg #(.W(DW + 1)) u_out_reg (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d    ({in_last, in_data}),
    .take (take),
    .full (reg_full),
    .q    (reg_q)
  );

  always_comb begin
    out_valid = '0;
    if (reg_full) out_valid[dest_q] = 1'b1;
  end

  assign out_data = reg_q[DW-1:0];
  assign out_last = reg_q[DW];
  assign busy     = (state != IDLE) | reg_full;

endmodule

// File: tb/tb_demux_router_ctrl.sv
// Scoreboard bench for demux_router_ctrl with directed packet vectors.
module tb_demux_router_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [3:0] en_mask = 4'hF;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic [3:0] out_ready = 4'hF;
  logic       busy;
  logic [7:0] drop_cnt;

  demux_router_ctrl #(.DW(8), .NOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .en_mask   (en_mask),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] port;
    logic [7:0] data;
    logic       last;
    logic       lat;
    int         due;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         vec = 0;
  int         miss = 0;
  int         cyc = 0;
  int         exp_drop = 0;
  logic       lat_chk = 1'b0;
  logic [7:0] pay [0:7];
  int         npay = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bump_drop();
    exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic push,
                           input logic [1:0] port);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      if (push) sb.push_back('{port, d, l, lat_chk, cyc + 1});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [3:0] mask_after);
    logic fwd;
    fwd = en_mask[hdr[1:0]] && (npay > 0);
    send_beat(hdr, npay == 0, 1'b0, 2'd0);
    en_mask = mask_after;
    if (npay == 0) bump_drop();
    for (int i = 0; i < npay; i++) send_beat(pay[i], i == npay - 1, fwd, hdr[1:0]);
    if (npay > 0 && !fwd) bump_drop();
  endtask

  task automatic chk_drop(input string name);
    @(negedge clk);
    check(name, {24'd0, drop_cnt}, exp_drop);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid != 4'd0) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", {20'd0, out_valid, out_data}, 32'd0);
      end else begin
        mon_e = sb[0];
        check("out_beat", {19'd0, out_valid, out_last, out_data},
              {19'd0, 4'b0001 << mon_e.port, mon_e.last, mon_e.data});
        if ((out_valid & out_ready) != 4'd0) begin
          if (mon_e.lat) check("latency", cyc, mon_e.due);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #3;
    check("reset_outputs", {19'd0, out_valid, out_last, out_data}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_drop_busy", {23'd0, busy, drop_cnt}, 32'd0);
    #20 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic forward to output 2 with one-cycle latency checks
    lat_chk = 1'b1;
    pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3; npay = 3;
    send_pkt(8'h02, 4'hF);
    lat_chk = 1'b0;
    idle(3);

    // Backpressure on output 1 mid-packet
    pay[0] = 8'hB1; pay[1] = 8'hB2; pay[2] = 8'hB3; pay[3] = 8'hB4; npay = 4;
    fork
      send_pkt(8'h01, 4'hF);
      begin
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (out_valid[1]) begin
            ok = 1'b1;
            break;
          end
        end
        check("bp_start", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 4'b1101;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_hold", {23'd0, out_last, out_data}, {23'd0, 1'b0, 8'hB2});
          check("bp_in_ready", {27'd0, in_ready, out_valid}, {27'd0, 1'b0, 4'b0010});
        end
        @(posedge clk);
        #1;
        out_ready = 4'hF;
      end
    join
    idle(3);

    // Disabled destination drops; enabled destination still forwards
    en_mask = 4'b1110;
    pay[0] = 8'hC1; pay[1] = 8'hC2; pay[2] = 8'hC3; npay = 3;
    send_pkt(8'h00, 4'b1110);
    chk_drop("drop_masked");
    pay[0] = 8'hD1; pay[1] = 8'hD2; npay = 2;
    send_pkt(8'h03, 4'b1110);
    idle(3);
    en_mask = 4'hF;

    // Header-only packets and counter saturation
    npay = 0;
    send_pkt(8'h01, 4'hF);
    chk_drop("drop_hdr_only");
    for (int i = 0; i < 256; i++) send_pkt(8'h02, 4'hF);
    chk_drop("drop_saturate");
    check("busy_idle", {31'd0, busy}, 32'd0);

    // Mask cleared after header: packet still forwarded
    pay[0] = 8'hE1; pay[1] = 8'hE2; pay[2] = 8'hE3; npay = 3;
    send_pkt(8'h02, 4'h0);
    idle(3);
    en_mask = 4'hF;
    chk_drop("drop_after_mask_change");

    // Asynchronous reset mid-packet
    send_beat(8'h02, 1'b0, 1'b0, 2'd0);
    send_beat(8'h11, 1'b0, 1'b1, 2'd2);
    send_beat(8'h12, 1'b0, 1'b1, 2'd2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {19'd0, out_valid, out_last, out_data}, 32'd0);
    check("async_rst_ready_busy", {30'd0, in_ready, busy}, 32'd0);
    check("async_rst_drop", {24'd0, drop_cnt}, 32'd0);
    sb.delete();
    exp_drop = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    pay[0] = 8'h33; npay = 1;
    send_pkt(8'h03, 4'hF);
    idle(5);

    check("scoreboard_empty", sb.size(), 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);
    chk_drop("final_drop");

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/demux_router_ctrl.md
DEMUX_ROUTER_CTRL -- requirements
Module: demux_router_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data width in bits.
REQ-002 SHALL have parameter NOUT, default 4, meaning number of output ports (power of two, at least 2); DEST_W = log2(NOUT).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  input beat valid.
REQ-006 SHALL have port in_data  input  DW  input beat data; on a header beat, bits [DEST_W-1:0] give the destination.
REQ-007 SHALL have port in_last  input  1  marks the final beat of a packet.
REQ-008 SHALL have port in_ready  output  1  input beat accepted when in_valid and in_ready are both 1.
REQ-009 SHALL have port en_mask  input  NOUT  per-output enable; a packet to a disabled output is dropped.
REQ-010 SHALL have port out_valid  output  NOUT  one-hot (or zero) valid, one bit per output.
REQ-011 SHALL have port out_data  output  DW  shared output data bus.
REQ-012 SHALL have port out_last  output  1  last-beat flag for the beat presented on out_data.
REQ-013 SHALL have port out_ready  input  NOUT  per-output ready.
REQ-014 SHALL have port busy  output  1  high whenever the FSM is not in IDLE or the output register is occupied.
REQ-015 SHALL have port drop_cnt  output  8  count of dropped packets, saturating at 255.

Function
REQ-016 SHALL implement FSM states IDLE, FWD and DROP; the first accepted beat in IDLE is the header.
REQ-017 IDLE: in_ready SHALL be 1 only when the output register is empty; the header beat SHALL be consumed and never forwarded.
REQ-018 Header transitions SHALL be: in_last=1 -> stay in IDLE and increment drop_cnt; en_mask[dest]=0 -> go to DROP; otherwise latch dest_q and go to FWD.
REQ-019 en_mask SHALL be sampled only at header acceptance; en_mask changes mid-packet SHALL have no effect on that packet.
REQ-020 FWD: in_ready SHALL equal (output register empty) OR out_ready[dest_q]; each accepted beat SHALL be loaded into the output register on the same edge.
REQ-021 Output register: a beat SHALL appear on out_data/out_last with out_valid[dest_q]=1 one cycle after acceptance; out_valid bits for other outputs SHALL be 0.
REQ-022 A simultaneous output handoff and input acceptance in the same cycle SHALL replace the register contents with no bubble, sustaining 1 beat/cycle.
REQ-023 out_data and out_last SHALL hold stable while out_valid is high and out_ready[dest_q] is 0.
REQ-024 An accepted in_last beat in FWD SHALL return the FSM to IDLE; the next header SHALL be accepted only after the last beat leaves the output register.
REQ-025 DROP: in_ready SHALL be 1 and beats SHALL be discarded; an accepted in_last beat SHALL increment drop_cnt and return the FSM to IDLE.
REQ-026 drop_cnt SHALL hold at 255 and never wrap.
REQ-027 A header with dest >= NOUT is impossible by construction, since dest is exactly DEST_W bits.

Reset
REQ-028 Asserting rst SHALL immediately force state=IDLE, output register empty, out_valid=0, out_data=0, out_last=0, dest_q=0 and drop_cnt=0, independent of clk.
REQ-029 On reset mid-packet, the partial packet SHALL be abandoned; after rst deasserts, the first accepted beat SHALL be treated as a header.
REQ-030 While rst is high, in_ready SHALL be 0.

Structure
REQ-031 Shared package demux_ctrl_pkg SHALL hold the FSM state enum (IDLE, FWD, DROP) and the DROP_CNT_MAX=255 constant.
REQ-032 The output register SHALL be one sub-module, demux_out_reg (one valid/ready register stage, DW+1 bits); FSM and counter logic SHALL reside in demux_router_ctrl.

Verification
REQ-033 With en_mask=4'b1111 and out_ready=all 1s, send header 0x02, payload 0xA1, 0xA2, 0xA3 (last) -> out_valid=4'b0100 with out_data A1, A2, A3 on consecutive cycles, each one cycle after acceptance, and out_last on A3.
REQ-034 Backpressure: send dest 1, 4 payload beats, and hold out_ready[1]=0 for 3 cycles mid-packet -> out_data stable, in_ready low while the register is full, and no beat lost or duplicated.
REQ-035 With en_mask=4'b1110, send header 0x00 plus 3 beats -> out_valid stays 0 and drop_cnt=1; a following packet to dest 3 forwards normally.
REQ-036 Send a header-only packet (in_last=1 on the header) -> no output beat and drop_cnt increments; after 256 drops, drop_cnt=255.
REQ-037 Assert rst asynchronously between clock edges after the 2nd payload beat -> outputs clear immediately; after release, beat 0x03 is taken as a header routing to output 3.
REQ-038 Change en_mask from 4'b1111 to 0 after the header -> the packet is still forwarded in full to dest_q.
